// File: rtl/direction_scheduler_if.sv
// Handshake bundle between the input/game-control side and the direction scheduler.
// Also carries the shared direction encoding so RTL and bench agree on it.
`ifndef LEFT_DIR
`define LEFT_DIR  2'b00
`endif
`ifndef RIGHT_DIR
`define RIGHT_DIR 2'b01
`endif
`ifndef UP_DIR
`define UP_DIR    2'b10
`endif
`ifndef DOWN_DIR
`define DOWN_DIR  2'b11
`endif

interface direction_scheduler_if #(
    parameter int DEPTH = 4
);
    logic [1:0]              i_dir;
    logic                    i_dir_valid;
    logic                    i_game_start;
    logic                    i_pause;
    logic                    i_game_over;
    logic [1:0]              o_direction;
    logic                    o_move;
    logic [$clog2(DEPTH):0]  o_count;
    logic                    o_drop;
    logic                    o_running;

    modport master (
        output i_dir, i_dir_valid, i_game_start, i_pause, i_game_over,
        input  o_direction, o_move, o_count, o_drop, o_running
    );

    modport slave (
        input  i_dir, i_dir_valid, i_game_start, i_pause, i_game_over,
        output o_direction, o_move, o_count, o_drop, o_running
    );
endinterface

// File: rtl/direction_scheduler.sv
// Snake direction scheduler: paces moves with a tick counter and buffers
// turn requests in a small FIFO, applying one queued turn per move.
module direction_scheduler #(
    parameter int DEPTH       = 4,
    parameter int TICK_CYCLES = 25_000_000
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    direction_scheduler_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int NW = PW + 1;
    localparam int CW = $clog2(TICK_CYCLES);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            move_q, move_d;
    logic            drop_q, drop_d;
    logic            running_q, running_d;
    logic [1:0]      dir_q, dir_d;
    logic [NW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [1:0]      fifo_q [DEPTH];

    logic [PW-1:0]   last_ptr;
    logic [1:0]      ref_dir;
    logic            req, redundant, full, enq, deq;

    always_comb begin
        last_ptr  = wr_q - PW'(1);
        ref_dir   = (count_q != '0) ? fifo_q[last_ptr] : dir_q;
        req       = bus.i_dir_valid && (state_q == RUN) && !bus.i_game_over;
        // Reversing straight into the body is as useless as repeating a turn.
        redundant = (bus.i_dir == ref_dir) || (bus.i_dir == (ref_dir ^ 2'b01));
        full      = (count_q == NW'(DEPTH));
        enq       = req && !redundant && (!full || move_q);
        drop_d    = req && !redundant && full && !move_q;
        deq       = move_q && (count_q != '0) && !bus.i_game_over;

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.i_game_start) state_d = RUN;
            end
            RUN: begin
                cnt_d = (cnt_q == TICK_LAST) ? '0 : cnt_q + CW'(1);
                if (bus.i_pause) state_d = PAUSED;
            end
            PAUSED: begin
                if (bus.i_pause) state_d = RUN;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (bus.i_game_over) begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        move_d    = (state_d == RUN) && (cnt_d == TICK_LAST);
        running_d = (state_d == RUN);
        dir_d     = deq ? fifo_q[rd_q] : dir_q;

        rd_d    = deq ? rd_q + PW'(1) : rd_q;
        wr_d    = enq ? wr_q + PW'(1) : wr_q;
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase
        if (bus.i_game_over) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            move_q    <= 1'b0;
            drop_q    <= 1'b0;
            running_q <= 1'b0;
            dir_q     <= `LEFT_DIR;
            count_q   <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= `LEFT_DIR;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            move_q    <= move_d;
            drop_q    <= drop_d;
            running_q <= running_d;
            dir_q     <= dir_d;
            count_q   <= count_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            if (enq) fifo_q[wr_q] <= bus.i_dir;
        end
    end

    assign bus.o_direction = dir_q;
    assign bus.o_move      = move_q;
    assign bus.o_count     = count_q;
    assign bus.o_drop      = drop_q;
    assign bus.o_running   = running_q;
endmodule

// File: tb/tb_direction_scheduler.sv
// Scenario bench for direction_scheduler (DEPTH=4, TICK_CYCLES=4); accepted turns
// go into a scoreboard and are matched against o_direction after each dequeuing move.
`ifndef LEFT_DIR
`define LEFT_DIR  2'b00
`endif
`ifndef RIGHT_DIR
`define RIGHT_DIR 2'b01
`endif
`ifndef UP_DIR
`define UP_DIR    2'b10
`endif
`ifndef DOWN_DIR
`define DOWN_DIR  2'b11
`endif

module tb_direction_scheduler;
    localparam logic [1:0] L = `LEFT_DIR;
    localparam logic [1:0] R = `RIGHT_DIR;
    localparam logic [1:0] U = `UP_DIR;
    localparam logic [1:0] D = `DOWN_DIR;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   pend = 1'b0;
    logic [1:0] sb [$];

    direction_scheduler_if #(.DEPTH(4)) bus ();

    direction_scheduler #(.DEPTH(4), .TICK_CYCLES(4)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge; a move seen with a non-empty queue means
    // the following sample must show the oldest scoreboard entry.
    task automatic tick();
        logic [1:0] exp;
        @(negedge clk);
        if (rst) pend = 1'b0;
        else begin
            if (pend) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_dir: dequeue seen, o_direction=%0d, scoreboard empty", bus.o_direction);
                end else begin
                    exp = sb.pop_front();
                    if (bus.o_direction !== exp) begin
                        n_err++;
                        $display("FAIL sb_dir: o_direction=%0d required=%0d", bus.o_direction, exp);
                    end
                end
            end
            pend = (bus.o_move === 1'b1) && (bus.o_count != 0);
        end
    endtask

    task automatic wait_move(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (bus.o_move === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL wait_move: o_move=0 required=1 within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        bus.i_dir = L; bus.i_dir_valid = 0; bus.i_game_start = 0;
        bus.i_pause = 0; bus.i_game_over = 0;
        rst = 1'b1;
        tick(); tick();
        n_cmp += 5;
        if (bus.o_running !== 1'b0) begin n_err++; $display("FAIL rst_running: %b required 0", bus.o_running); end
        if (bus.o_move !== 1'b0) begin n_err++; $display("FAIL rst_move: %b required 0", bus.o_move); end
        if (bus.o_drop !== 1'b0) begin n_err++; $display("FAIL rst_drop: %b required 0", bus.o_drop); end
        if (bus.o_count !== 3'd0) begin n_err++; $display("FAIL rst_count: %0d required 0", bus.o_count); end
        if (bus.o_direction !== L) begin n_err++; $display("FAIL rst_dir: %0d required %0d", bus.o_direction, L); end
        rst = 1'b0;
        tick(); tick();
        n_cmp += 2;
        if (bus.o_running !== 1'b0) begin n_err++; $display("FAIL idle_running: %b required 0", bus.o_running); end
        if (bus.o_move !== 1'b0) begin n_err++; $display("FAIL idle_move: %b required 0", bus.o_move); end
    endtask

    task automatic test_start_tick();
        bus.i_game_start = 1;
        tick();
        bus.i_game_start = 0;
        n_cmp++;
        if (bus.o_running !== 1'b1) begin n_err++; $display("FAIL start_running: %b required 1", bus.o_running); end
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            n_cmp += 2;
            if (bus.o_move !== ((i % 4) == 3)) begin
                n_err++; $display("FAIL tick_move[%0d]: %b required %b", i, bus.o_move, (i % 4) == 3);
            end
            if (bus.o_direction !== L) begin
                n_err++; $display("FAIL tick_dir[%0d]: %0d required %0d", i, bus.o_direction, L);
            end
        end
    endtask

    task automatic test_queue_order();
        tick();
        bus.i_dir = U; bus.i_dir_valid = 1; sb.push_back(U);
        tick();
        bus.i_dir = L; sb.push_back(L);
        tick();
        bus.i_dir = R;
        tick();
        bus.i_dir_valid = 0;
        n_cmp += 2;
        if (bus.o_count !== 3'd2) begin n_err++; $display("FAIL order_count: %0d required 2", bus.o_count); end
        if (bus.o_drop !== 1'b0) begin n_err++; $display("FAIL order_drop: %b required 0", bus.o_drop); end
        tick();
        n_cmp += 2;
        if (bus.o_direction !== U) begin n_err++; $display("FAIL order_dir1: %0d required %0d", bus.o_direction, U); end
        if (bus.o_count !== 3'd1) begin n_err++; $display("FAIL order_count1: %0d required 1", bus.o_count); end
        wait_move(8);
        tick();
        n_cmp += 2;
        if (bus.o_direction !== L) begin n_err++; $display("FAIL order_dir2: %0d required %0d", bus.o_direction, L); end
        if (bus.o_count !== 3'd0) begin n_err++; $display("FAIL order_count2: %0d required 0", bus.o_count); end
    endtask

    task automatic test_reject();
        bus.i_dir = R; bus.i_dir_valid = 1;
        tick();
        bus.i_dir_valid = 0;
        n_cmp += 2;
        if (bus.o_count !== 3'd0) begin n_err++; $display("FAIL opp_count: %0d required 0", bus.o_count); end
        if (bus.o_drop !== 1'b0) begin n_err++; $display("FAIL opp_drop: %b required 0", bus.o_drop); end
        bus.i_dir = L; bus.i_dir_valid = 1;
        tick();
        bus.i_dir_valid = 0;
        n_cmp += 3;
        if (bus.o_count !== 3'd0) begin n_err++; $display("FAIL dup_count: %0d required 0", bus.o_count); end
        if (bus.o_drop !== 1'b0) begin n_err++; $display("FAIL dup_drop: %b required 0", bus.o_drop); end
        if (bus.o_direction !== L) begin n_err++; $display("FAIL dup_dir: %0d required %0d", bus.o_direction, L); end
    endtask

    task automatic test_full_drop();
        wait_move(8);
        bus.i_dir = U; bus.i_dir_valid = 1; sb.push_back(U);
        tick();
        n_cmp += 2;
        if (bus.o_count !== 3'd1) begin n_err++; $display("FAIL nobypass_count: %0d required 1", bus.o_count); end
        if (bus.o_direction !== L) begin n_err++; $display("FAIL nobypass_dir: %0d required %0d", bus.o_direction, L); end
        bus.i_dir = L; sb.push_back(L);
        tick();
        bus.i_dir = D; sb.push_back(D);
        tick();
        bus.i_dir = R; sb.push_back(R);
        tick();
        n_cmp += 2;
        if (bus.o_count !== 3'd4) begin n_err++; $display("FAIL fill_count: %0d required 4", bus.o_count); end
        if (bus.o_move !== 1'b1) begin n_err++; $display("FAIL fill_move: %b required 1", bus.o_move); end
        bus.i_dir = U; sb.push_back(U);
        tick();
        n_cmp += 2;
        if (bus.o_count !== 3'd4) begin n_err++; $display("FAIL fullmove_count: %0d required 4", bus.o_count); end
        if (bus.o_drop !== 1'b0) begin n_err++; $display("FAIL fullmove_drop: %b required 0", bus.o_drop); end
        bus.i_dir = L;
        tick();
        bus.i_dir_valid = 0;
        n_cmp += 2;
        if (bus.o_drop !== 1'b1) begin n_err++; $display("FAIL drop_pulse: %b required 1", bus.o_drop); end
        if (bus.o_count !== 3'd4) begin n_err++; $display("FAIL drop_count: %0d required 4", bus.o_count); end
        tick();
        n_cmp++;
        if (bus.o_drop !== 1'b0) begin n_err++; $display("FAIL drop_clear: %b required 0", bus.o_drop); end
        tick();
        n_cmp++;
        if (bus.o_move !== 1'b1) begin n_err++; $display("FAIL full_move2: %b required 1", bus.o_move); end
        bus.i_dir = R; bus.i_dir_valid = 1; sb.push_back(R);
        tick();
        bus.i_dir_valid = 0;
        n_cmp += 2;
        if (bus.o_count !== 3'd4) begin n_err++; $display("FAIL fullmove2_count: %0d required 4", bus.o_count); end
        if (bus.o_drop !== 1'b0) begin n_err++; $display("FAIL fullmove2_drop: %b required 0", bus.o_drop); end
    endtask

    task automatic test_pause();
        tick();
        bus.i_pause = 1;
        tick();
        bus.i_pause = 0;
        n_cmp += 2;
        if (bus.o_running !== 1'b0) begin n_err++; $display("FAIL pause_running: %b required 0", bus.o_running); end
        if (bus.o_move !== 1'b0) begin n_err++; $display("FAIL pause_move: %b required 0", bus.o_move); end
        bus.i_dir = U; bus.i_dir_valid = 1;
        tick();
        bus.i_dir_valid = 0;
        n_cmp += 2;
        if (bus.o_count !== 3'd4) begin n_err++; $display("FAIL pause_count: %0d required 4", bus.o_count); end
        if (bus.o_drop !== 1'b0) begin n_err++; $display("FAIL pause_drop: %b required 0", bus.o_drop); end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if (bus.o_move !== 1'b0 || bus.o_running !== 1'b0) begin
                n_err++; $display("FAIL pause_hold[%0d]: move=%b running=%b required 0/0", i, bus.o_move, bus.o_running);
            end
        end
        bus.i_pause = 1;
        tick();
        bus.i_pause = 0;
        n_cmp += 2;
        if (bus.o_running !== 1'b1) begin n_err++; $display("FAIL resume_running: %b required 1", bus.o_running); end
        if (bus.o_move !== 1'b0) begin n_err++; $display("FAIL resume_move0: %b required 0", bus.o_move); end
        tick();
        n_cmp++;
        if (bus.o_move !== 1'b1) begin n_err++; $display("FAIL resume_move1: %b required 1", bus.o_move); end
        tick();
    endtask

    task automatic test_game_over();
        n_cmp += 2;
        if (bus.o_count !== 3'd3) begin n_err++; $display("FAIL go_pre_count: %0d required 3", bus.o_count); end
        if (bus.o_direction !== D) begin n_err++; $display("FAIL go_pre_dir: %0d required %0d", bus.o_direction, D); end
        bus.i_game_over = 1;
        tick();
        bus.i_game_over = 0;
        sb.delete();
        n_cmp += 3;
        if (bus.o_running !== 1'b0) begin n_err++; $display("FAIL go_running: %b required 0", bus.o_running); end
        if (bus.o_count !== 3'd0) begin n_err++; $display("FAIL go_count: %0d required 0", bus.o_count); end
        if (bus.o_direction !== D) begin n_err++; $display("FAIL go_dir: %0d required %0d", bus.o_direction, D); end
        tick(); tick();
        n_cmp++;
        if (bus.o_move !== 1'b0) begin n_err++; $display("FAIL go_idle_move: %b required 0", bus.o_move); end
    endtask

    task automatic test_async_reset();
        bus.i_game_start = 1;
        tick();
        bus.i_game_start = 0;
        wait_move(8);
        bus.i_dir = R; bus.i_dir_valid = 1;
        tick();
        bus.i_dir_valid = 0;
        n_cmp++;
        if (bus.o_count !== 3'd1) begin n_err++; $display("FAIL ar_pre_count: %0d required 1", bus.o_count); end
        wait_move(8);
        #2 rst = 1'b1;
        #1;
        n_cmp += 5;
        if (bus.o_running !== 1'b0) begin n_err++; $display("FAIL ar_running: %b required 0", bus.o_running); end
        if (bus.o_move !== 1'b0) begin n_err++; $display("FAIL ar_move: %b required 0", bus.o_move); end
        if (bus.o_drop !== 1'b0) begin n_err++; $display("FAIL ar_drop: %b required 0", bus.o_drop); end
        if (bus.o_count !== 3'd0) begin n_err++; $display("FAIL ar_count: %0d required 0", bus.o_count); end
        if (bus.o_direction !== L) begin n_err++; $display("FAIL ar_dir: %0d required %0d", bus.o_direction, L); end
        sb.delete();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (bus.o_move !== 1'b0 || bus.o_running !== 1'b0) begin
                n_err++; $display("FAIL ar_stay_idle[%0d]: move=%b running=%b required 0/0", i, bus.o_move, bus.o_running);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_tick();
        test_queue_order();
        test_reject();
        test_full_drop();
        test_pause();
        test_game_over();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
